// File: rtl/hyperbus_clk_pkg.sv
// Shared types and defaults for the HyperBus CK/CK# generator.
package hyperbus_clk_pkg;

  localparam int unsigned DivWidthDefault = 4;

  typedef enum logic {G_IDLE, G_RUN} glob_state_e;
  typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;

endpackage

// File: rtl/hyperbus_clk_div.sv
// Half-period divider for the HyperBus clock: counter, phase flop, latched ratio
// and rising/falling tick decode.
module hyperbus_clk_div
  import hyperbus_clk_pkg::*;
#(
  parameter int unsigned DivWidth = DivWidthDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DivWidth-1:0] div_i,
  input  logic                run,
  input  logic                stop,
  output logic                rise_tick,
  output logic                fall_tick,
  output logic                ph_next
);

  logic [DivWidth-1:0] cnt_q;
  logic [DivWidth-1:0] div_q;
  logic                ph_q;
  logic                tick;

  always_comb begin
    tick      = run && (cnt_q == div_q);
    rise_tick = tick && !ph_q;
    fall_tick = tick && ph_q;
    ph_next   = ph_q;
    if (!run) begin
      ph_next = 1'b0;
    end else if (rise_tick) begin
      // A stopping rising tick leaves the phase low so CK never restarts with a runt.
      ph_next = !stop;
    end else if (fall_tick) begin
      ph_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      ph_q <= ph_next;
      if (!run) begin
        cnt_q <= '0;
        div_q <= div_i;
      end else if (tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyperbus_clk_gen.sv
// Per-channel glitch-free HyperBus CK/CK# generator with rise/fall strobes.
// HYPERBUS_CLK_DIFF_EN: when defined, CK# is a registered inverse of CK; otherwise tied high.
module hyperbus_clk_gen
  import hyperbus_clk_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned DivWidth    = DivWidthDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DivWidth-1:0]    div_i,
  input  logic [NumChannels-1:0] en_i,
  output logic [NumChannels-1:0] ck_o,
  output logic [NumChannels-1:0] ck_no,
  output logic [NumChannels-1:0] active_o,
  output logic                   busy_o,
  output logic                   rise_o,
  output logic                   fall_o
);

  glob_state_e            g_q, g_d;
  ch_state_e              ch_q [NumChannels];
  ch_state_e              ch_d [NumChannels];
  logic [NumChannels-1:0] run_d;
  logic [NumChannels-1:0] ck_d;
  logic [NumChannels-1:0] ck_q;
  logic [NumChannels-1:0] active_q;
  logic                   busy_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   rise_tick;
  logic                   fall_tick;
  logic                   ph_next;
  logic                   stop;

  assign stop = rise_tick && (en_i == '0);

  hyperbus_clk_div #(
    .DivWidth (DivWidth)
  ) u_div (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .div_i     (div_i),
    .run       (g_q == G_RUN),
    .stop      (stop),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .ph_next   (ph_next)
  );

  always_comb begin
    g_d = g_q;
    if (g_q == G_IDLE) begin
      if (en_i != '0) g_d = G_RUN;
    end else if (stop) begin
      g_d = G_IDLE;
    end
    // Channels only join or leave on a rising tick, keeping pulses whole and aligned.
    for (int unsigned c = 0; c < NumChannels; c++) begin
      ch_d[c] = ch_q[c];
      if (rise_tick) ch_d[c] = en_i[c] ? CH_RUN : CH_IDLE;
      run_d[c] = (ch_d[c] == CH_RUN);
      ck_d[c]  = ph_next && run_d[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_q <= G_IDLE;
      for (int unsigned c = 0; c < NumChannels; c++) ch_q[c] <= CH_IDLE;
      ck_q     <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      g_q <= g_d;
      for (int unsigned c = 0; c < NumChannels; c++) ch_q[c] <= ch_d[c];
      ck_q     <= ck_d;
      active_q <= run_d;
      busy_q   <= (g_d == G_RUN);
      rise_q   <= rise_tick && !stop;
      fall_q   <= fall_tick;
    end
  end

  assign ck_o     = ck_q;
  assign active_o = active_q;
  assign busy_o   = busy_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

`ifdef HYPERBUS_CLK_DIFF_EN
  logic [NumChannels-1:0] ck_n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ck_n_q <= '1;
    end else begin
      ck_n_q <= ~ck_d;
    end
  end

  assign ck_no = ck_n_q;
`else
  assign ck_no = '1;
`endif

endmodule

// File: tb/tb_hyperbus_clk_gen.sv
// Directed self-checking bench for hyperbus_clk_gen (2 channels, 4-bit divider).
module tb_hyperbus_clk_gen;

  logic       clk_i;
  logic       rst_ni;
  logic [3:0] div_i;
  logic [1:0] en_i;
  logic [1:0] ck_o;
  logic [1:0] ck_no;
  logic [1:0] active_o;
  logic       busy_o;
  logic       rise_o;
  logic       fall_o;

  int checks = 0;
  int errors = 0;

  hyperbus_clk_gen #(
    .NumChannels (2),
    .DivWidth    (4)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .div_i    (div_i),
    .en_i     (en_i),
    .ck_o     (ck_o),
    .ck_no    (ck_no),
    .active_o (active_o),
    .busy_o   (busy_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single channel started at cycle 0 with half-period d+1: first high at 2+d, period 2(d+1).
  function automatic int phase_of(int k, int d);
    return (k - 2 - d) % (2 * (d + 1));
  endfunction
  function automatic logic ck_model(int k, int d);
    return (k >= 2 + d) && (phase_of(k, d) < d + 1);
  endfunction
  function automatic logic rise_model(int k, int d);
    return (k >= 2 + d) && (phase_of(k, d) == 0);
  endfunction
  function automatic logic fall_model(int k, int d);
    return (k >= 2 + d) && (phase_of(k, d) == d + 1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(string tag, int k, logic [1:0] ck, logic [1:0] act,
                     logic busy, logic rise, logic fall);
    logic [1:0] ckn;
`ifdef HYPERBUS_CLK_DIFF_EN
    ckn = ~ck;
`else
    ckn = 2'b11;
`endif
    check($sformatf("%s ck k=%0d", tag, k), 32'(ck_o), 32'(ck));
    check($sformatf("%s ckn k=%0d", tag, k), 32'(ck_no), 32'(ckn));
    check($sformatf("%s active k=%0d", tag, k), 32'(active_o), 32'(act));
    check($sformatf("%s busy k=%0d", tag, k), 32'(busy_o), 32'(busy));
    check($sformatf("%s rise k=%0d", tag, k), 32'(rise_o), 32'(rise));
    check($sformatf("%s fall k=%0d", tag, k), 32'(fall_o), 32'(fall));
    @(posedge clk_i);
    #1;
  endtask

  // Channel 0 requested from cycle 0 to stop_k-1; e is the hand-computed exit rising-tick cycle.
  task automatic run_single(string tag, int d, int stop_k, int e, int chg_k, int chg_div);
    for (int k = 0; k <= e + 2; k++) begin
      en_i  = (k < stop_k) ? 2'b01 : 2'b00;
      div_i = (k >= chg_k) ? 4'(chg_div) : 4'(d);
      cyc(tag, k, {1'b0, ck_model(k, d) && k <= e},
          {1'b0, k >= 2 + d && k <= e}, k >= 1 && k <= e,
          rise_model(k, d) && k <= e, fall_model(k, d) && k <= e);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    en_i   = 2'b00;
    div_i  = 4'd0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    cyc("in_reset", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    for (int k = 0; k < 20; k++) cyc("idle", k, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // D=0: CK = clk/2, first high in cycle 2, exits one rising tick after en drops.
    run_single("d0", 0, 10, 11, 99, 0);

    // D=2: channel 1 requested mid-high pulse joins phase-aligned at the next rise (cycle 10).
    for (int k = 0; k <= 29; k++) begin
      en_i  = {k >= 5 && k < 22, k < 22};
      div_i = 4'd2;
      cyc("join", k,
          {ck_model(k, 2) && k >= 10 && k <= 27, ck_model(k, 2) && k <= 27},
          {k >= 10 && k <= 27, k >= 4 && k <= 27}, k >= 1 && k <= 27,
          rise_model(k, 2) && k <= 27, fall_model(k, 2) && k <= 27);
    end

    // D=3: en dropped one cycle after the rise; high pulse 5..8 completes, low 9..12, idle at 13.
    run_single("d3stop", 3, 6, 12, 99, 3);

    // div_i moved 1->3 while running: period stays 4; the next start uses period 8.
    run_single("frozen", 1, 15, 18, 4, 3);
    run_single("newdiv", 3, 6, 12, 99, 3);

    // Asynchronous reset in the middle of a high pulse.
    div_i = 4'd3;
    en_i  = 2'b01;
    repeat (6) begin
      @(posedge clk_i);
      #1;
    end
    check("prereset ck", 32'(ck_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async ck", 32'(ck_o), 32'd0);
    check("async ckn", 32'(ck_no), 32'd3);
    check("async busy", 32'(busy_o), 32'd0);
    check("async active", 32'(active_o), 32'd0);
    en_i = 2'b00;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run_single("postrst", 0, 10, 11, 99, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
